// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: FSM encoding, command
// byte field positions and shadow register geometry.
package spi_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    localparam logic [7:0] CMD_TEST     = 8'h8F;
    localparam int         NUM_CFG_REGS = 4;
    localparam int         WR_BIT       = 7;
    localparam int         RD_BIT       = 0;
    localparam int         ADDR_MSB     = 6;
    localparam int         ADDR_LSB     = 5;

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Byte stream from the SPI peripheral, vblank strobe, and decoder outputs.
// byte_valid is a one-cycle pulse with no backpressure; the decoder must
// accept every pulse, so there is no ready signal.
interface spi_cmd_decoder_if #(parameter int CNT_W = 8);
    import spi_cfg_pkg::*;

    logic             ss_n;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             vblank;
    logic [31:0]      config_data;
    logic [31:0]      readback_data;
    logic             commit;
    logic             pending;
    logic             busy;
    logic [CNT_W-1:0] write_count;
    state_t           state;

    modport master (
        output ss_n, byte_data, byte_valid, vblank,
        input  config_data, readback_data, commit, pending, busy, write_count, state
    );

    modport slave (
        input  ss_n, byte_data, byte_valid, vblank,
        output config_data, readback_data, commit, pending, busy, write_count, state
    );

endinterface

// File: rtl/spi_cmd_decoder_sync_edge_detect.sv
// Two-flop synchroniser with rise/fall pulse outputs. Flops reset high so
// an idle (deselected) slave-select produces no edge out of reset.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command frames into burst writes of four shadow registers and
// copies them atomically into the active configuration on vertical blank.
module spi_cmd_decoder
    import spi_cfg_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter int          CNT_W       = 8
) (
    input logic               clk,
    input logic               rst,
    spi_cmd_decoder_if.slave  bus
);

    state_t                      state_q, state_d;
    logic                        frame_start, frame_end;
    logic                        cmd_is_write;
    logic                        do_write, do_commit, frame_done;
    logic [1:0]                  addr_q;
    logic [NUM_CFG_REGS*8-1:0]   shadow_q;
    logic [NUM_CFG_REGS*8-1:0]   active_q;
    logic                        dirty_q, pending_q, commit_q;
    logic [CNT_W-1:0]            count_q;

    sync_edge_detect u_ss_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.ss_n),
        .rise     (frame_end),
        .fall     (frame_start)
    );

    assign cmd_is_write = bus.byte_data[WR_BIT] & ~bus.byte_data[RD_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (frame_start)    state_d = ST_CMD;
            ST_CMD:  if (bus.byte_valid) state_d = cmd_is_write ? ST_DATA : ST_SKIP;
            default: state_d = state_q;
        endcase
        // The byte in a frame_end cycle is still consumed by the datapath.
        if (frame_end && state_q != ST_IDLE) state_d = ST_IDLE;
    end

    always_comb begin
        do_write   = (state_q == ST_DATA) && bus.byte_valid;
        frame_done = frame_end && (state_q != ST_IDLE);
        do_commit  = bus.vblank && pending_q && (state_q == ST_IDLE) && !frame_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= 2'd0;
            shadow_q  <= RESET_VALUE;
            active_q  <= RESET_VALUE;
            dirty_q   <= 1'b0;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            commit_q <= do_commit;
            if (state_q == ST_CMD && bus.byte_valid && cmd_is_write)
                addr_q <= bus.byte_data[ADDR_MSB:ADDR_LSB];
            if (do_write) begin
                shadow_q[{addr_q, 3'b000} +: 8] <= bus.byte_data;
                addr_q <= addr_q + 2'd1;
                if (count_q != '1) count_q <= count_q + 1'b1;
            end
            // A write landing on the frame_end cycle still marks the update complete.
            if (frame_done) begin
                pending_q <= pending_q | dirty_q | do_write;
                dirty_q   <= 1'b0;
            end else if (do_write) begin
                dirty_q <= 1'b1;
            end
            if (do_commit) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.config_data   = active_q;
    assign bus.readback_data = shadow_q;
    assign bus.commit        = commit_q;
    assign bus.pending       = pending_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.write_count   = count_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: register-array model updated per frame
// event, per-cycle comparison, and literal checks pinning the model.
module tb_spi_cmd_decoder;
    import spi_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_cmd_decoder_if #(.CNT_W(8)) bus ();

    spi_cmd_decoder #(.RESET_VALUE(32'h0000_0000), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: registers as a byte array, frame phase as the named states.
    logic [7:0] m_shadow [4];
    logic [7:0] m_config [4];
    logic       m_pending, m_commit, m_dirty;
    int         m_count;
    int         m_addr;
    state_t     m_state;

    function automatic logic [31:0] pack(input logic [7:0] r [4]);
        return {r[3], r[2], r[1], r[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 8'h00;
            m_config[i] = 8'h00;
        end
        m_pending = 0; m_commit = 0; m_dirty = 0;
        m_count = 0; m_addr = 0; m_state = ST_IDLE;
    endtask

    function automatic void model_byte(input logic [7:0] b);
        case (m_state)
            ST_CMD: begin
                if (b[7] && !b[0]) begin
                    m_state = ST_DATA;
                    m_addr  = int'(b[6:5]);
                end else begin
                    m_state = ST_SKIP;
                end
            end
            ST_DATA: begin
                m_shadow[m_addr] = b;
                m_addr  = (m_addr + 1) % 4;
                m_count = (m_count < 255) ? m_count + 1 : 255;
                m_dirty = 1;
            end
            default: ;
        endcase
    endfunction

    function automatic void model_frame_end();
        if (m_state != ST_IDLE) begin
            if (m_dirty) m_pending = 1;
            m_dirty = 0;
            m_state = ST_IDLE;
        end
    endfunction

    function automatic void model_vblank();
        if (m_pending && m_state == ST_IDLE) begin
            m_config  = m_shadow;
            m_pending = 0;
            m_commit  = 1;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("config_data",   bus.config_data,   pack(m_config));
            check("readback_data", bus.readback_data, pack(m_shadow));
            check("pending",       32'(bus.pending),  32'(m_pending));
            check("commit",        32'(bus.commit),   32'(m_commit));
            check("busy",          32'(bus.busy),     32'(m_state != ST_IDLE));
            check("write_count",   32'(bus.write_count), 32'(m_count));
            check("state",         32'(bus.state),    32'(m_state));
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic ss_low();
        bus.ss_n = 1'b0;
        repeat (3) @(posedge clk);
        if (m_state == ST_IDLE) m_state = ST_CMD;
        #1;
    endtask

    task automatic ss_high();
        bus.ss_n = 1'b1;
        repeat (3) @(posedge clk);
        model_frame_end();
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        @(posedge clk);
        model_byte(b);
        #1 bus.byte_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic end_with_byte(input logic [7:0] b);
        bus.ss_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        @(posedge clk);
        model_byte(b);
        model_frame_end();
        #1 bus.byte_valid = 1'b0;
    endtask

    task automatic end_with_vblank();
        bus.ss_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.vblank = 1'b1;
        @(posedge clk);
        model_vblank();
        model_frame_end();
        #1 bus.vblank = 1'b0;
        check("commit_at_frame_end_lit", 32'(bus.commit), 32'd0);
        @(posedge clk);
        m_commit = 0;
        #1;
    endtask

    task automatic do_vblank(input logic exp_commit);
        bus.vblank = 1'b1;
        @(posedge clk);
        model_vblank();
        #1 bus.vblank = 1'b0;
        check("commit_lit", 32'(bus.commit), 32'(exp_commit));
        @(posedge clk);
        m_commit = 0;
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        bus.ss_n = 1'b1; bus.byte_data = 8'h00; bus.byte_valid = 1'b0; bus.vblank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_config_lit",   bus.config_data,   32'h0);
        check("rst_readback_lit", bus.readback_data, 32'h0);
        check("rst_flags_lit",    {29'd0, bus.commit, bus.pending, bus.busy}, 32'h0);
        check("rst_count_lit",    32'(bus.write_count), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        do_vblank(1'b0);
        check("idle_vblank_config_lit", bus.config_data, 32'h0);

        // Burst write from address 1.
        ss_low(); send_byte(8'hA0); send_byte(8'h11); send_byte(8'h22); ss_high();
        check("a0_readback_lit", bus.readback_data, 32'h0022_1100);
        check("a0_pending_lit",  32'(bus.pending), 32'd1);
        do_vblank(1'b1);
        check("a0_config_lit",   bus.config_data, 32'h0022_1100);
        check("a0_cleared_lit",  32'(bus.pending), 32'd0);

        // Burst from address 3 wraps to 0 and 1.
        ss_low(); send_byte(8'hE0); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); ss_high();
        check("e0_readback_lit", bus.readback_data, 32'h0122_0302);
        check("e0_count_lit",    32'(bus.write_count), 32'd5);
        do_vblank(1'b1);
        check("e0_config_lit",   bus.config_data, 32'h0122_0302);

        // TEST and READ frames are skipped.
        ss_low(); send_byte(8'h8F);
        check("test_skip_lit", 32'(bus.state), 32'(ST_SKIP));
        send_byte(8'h55); ss_high();
        ss_low(); send_byte(8'hC1); send_byte(8'h77); ss_high();
        check("skip_readback_lit", bus.readback_data, 32'h0122_0302);
        check("skip_pending_lit",  32'(bus.pending), 32'd0);

        // vblank mid-frame is held off until after frame end.
        ss_low(); send_byte(8'h80); send_byte(8'h5A);
        do_vblank(1'b0);
        ss_high();
        do_vblank(1'b1);
        check("mid_vblank_config_lit", bus.config_data, 32'h0122_035A);

        // Byte coinciding with frame end is still written.
        ss_low(); send_byte(8'hA0); send_byte(8'h33); end_with_byte(8'h44);
        check("coinc_readback_lit", bus.readback_data, 32'h0144_335A);
        check("coinc_count_lit",    32'(bus.write_count), 32'd8);
        // Zero-byte frame and a NOP frame ending on vblank keep pending.
        ss_low(); ss_high();
        check("empty_pending_lit", 32'(bus.pending), 32'd1);
        ss_low(); send_byte(8'h00); end_with_vblank();
        check("nop_vblank_config_lit", bus.config_data, 32'h0122_035A);
        do_vblank(1'b1);
        check("late_commit_config_lit", bus.config_data, 32'h0144_335A);

        // Asynchronous reset mid-DATA.
        ss_low(); send_byte(8'hA0); send_byte(8'h99);
        #2 rst = 1'b1;
        bus.ss_n = 1'b1;
        model_reset();
        #1;
        check("arst_config_lit",   bus.config_data,   32'h0);
        check("arst_readback_lit", bus.readback_data, 32'h0);
        check("arst_flags_lit",    {29'd0, bus.commit, bus.pending, bus.busy}, 32'h0);
        check("arst_count_lit",    32'(bus.write_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Write counter saturation.
        ss_low(); send_byte(8'h80);
        for (int i = 0; i < 260; i++) send_byte(8'(i));
        ss_high();
        check("sat_count_lit", 32'(bus.write_count), 32'd255);
        do_vblank(1'b1);

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
